id_insn_queue: RTL and testbench



---
 rtl/id_insn_queue.sv | 113 +++++++++++
 tb/tb_id_insn_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_insn_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_insn_queue
// Purpose  : DEPTH-entry instruction FIFO between fetch and decode, with
//            load-use hold-back, single-cycle flush and hazard stall counter.
// Revision : 1.0  initial release
// ============================================================================
module id_insn_queue #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 4,
    parameter int RS0_LSB = 21,
    parameter int RS1_LSB = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     if_en,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [DATA_W-1:0]        if_insn,
    output logic                     if_ready,
    output logic                     q_en,
    output logic [ADDR_W-1:0]        q_pc,
    output logic [DATA_W-1:0]        q_insn,
    output logic [REG_AW-1:0]        q_rs0,
    output logic [REG_AW-1:0]        q_rs1,
    input  logic                     dec_ready,
    input  logic                     ex_en,
    input  logic                     ex_is_load,
    input  logic [REG_AW-1:0]        ex_dst_addr,
    output logic                     ld_hazard,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         ld_stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] c_full      = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_stall_max = '1;

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_insn_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_push;
    logic w_pop;

    assign if_ready = (r_count != c_full);
    assign q_en     = (r_count != '0);

    // Head is forced to zero when empty so decode never sees stale entries.
    assign q_pc   = q_en ? r_pc_mem[r_rd_ptr]   : '0;
    assign q_insn = q_en ? r_insn_mem[r_rd_ptr] : '0;
    assign q_rs0  = q_insn[RS0_LSB +: REG_AW];
    assign q_rs1  = q_insn[RS1_LSB +: REG_AW];

    assign ld_hazard = q_en & ex_en & ex_is_load &
                       ((ex_dst_addr == q_rs0) | (ex_dst_addr == q_rs1));

    assign w_push = if_en & if_ready & ~flush;
    assign w_pop  = q_en & dec_ready & ~ld_hazard & ~flush;

    assign count        = r_count;
    assign ld_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= if_pc;
            r_insn_mem[r_wr_ptr] <= if_insn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Performance counter survives flushes; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (ld_hazard && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_insn_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_insn_queue
// Purpose  : Directed self-checking bench for id_insn_queue (DEPTH=4, CNT_W=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_id_insn_queue;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset, flush, if_en, dec_ready, ex_en, ex_is_load;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_insn;
    logic [REG_AW-1:0] ex_dst_addr;
    logic              if_ready, q_en, ld_hazard;
    logic [ADDR_W-1:0] q_pc;
    logic [DATA_W-1:0] q_insn;
    logic [REG_AW-1:0] q_rs0, q_rs1;
    logic [2:0]        count;
    logic [CNT_W-1:0]  ld_stall_cnt;

    int checks = 0;
    int errors = 0;

    id_insn_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
        .RS0_LSB(21), .RS1_LSB(16), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn), .if_ready(if_ready),
        .q_en(q_en), .q_pc(q_pc), .q_insn(q_insn), .q_rs0(q_rs0), .q_rs1(q_rs1),
        .dec_ready(dec_ready), .ex_en(ex_en), .ex_is_load(ex_is_load),
        .ex_dst_addr(ex_dst_addr), .ld_hazard(ld_hazard),
        .count(count), .ld_stall_cnt(ld_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // rs0 = pc[4:0], rs1 = ~pc[4:0]; low half carries the PC for easy tracing.
    function automatic logic [DATA_W-1:0] mk_insn(input logic [ADDR_W-1:0] pc);
        return {6'h2a, pc[4:0], ~pc[4:0], pc[15:0]};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_push(input logic [ADDR_W-1:0] pc);
        if_en   = 1'b1;
        if_pc   = pc;
        if_insn = mk_insn(pc);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (if_ready !== 1'b1 || q_en !== 1'b0 || q_pc !== '0 || q_insn !== '0 ||
            q_rs0 !== '0 || q_rs1 !== '0 || ld_hazard !== 1'b0 ||
            count !== 3'd0 || ld_stall_cnt !== '0) begin
            errors++;
            $display("FAIL %s: got rdy=%b qen=%b pc=%h insn=%h rs0=%0d rs1=%0d hz=%b cnt=%0d st=%0d, want rdy=1 qen=0 all zero",
                     tag, if_ready, q_en, q_pc, q_insn, q_rs0, q_rs1, ld_hazard, count, ld_stall_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; if_en = 1'b0; if_pc = '0; if_insn = '0;
        dec_ready = 1'b0; ex_en = 1'b0; ex_is_load = 1'b0; ex_dst_addr = '0;
        step(); step();
        reset = 1'b0;
        check_reset_values("reset_state");
    endtask

    task automatic test_fill_drain();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(ADDR_W'(32'h100 + i));
            step();
            checks++;
            if (count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
            end
        end
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_if_ready: got %b want 0", if_ready);
        end
        drive_push(ADDR_W'(32'h104));
        step();
        if_en = 1'b0;
        checks++;
        if (count !== 3'd4 || q_pc !== ADDR_W'(32'h100)) begin
            errors++;
            $display("FAIL fifth_push_dropped: got cnt=%0d pc=%h want cnt=4 pc=100", count, q_pc);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_en !== 1'b1 || q_pc !== ADDR_W'(32'h100 + i) ||
                q_insn !== mk_insn(ADDR_W'(32'h100 + i)) || q_rs0 !== 5'(32'h100 + i) ||
                q_rs1 !== ~5'(32'h100 + i)) begin
                errors++;
                $display("FAIL drain[%0d]: got qen=%b pc=%h insn=%h rs0=%0d rs1=%0d want pc=%h",
                         i, q_en, q_pc, q_insn, q_rs0, q_rs1, 32'h100 + i);
            end
            step();
        end
        checks++;
        if (q_en !== 1'b0 || count !== 3'd0 || q_pc !== '0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL drained_empty: got qen=%b cnt=%0d pc=%h rdy=%b want 0 0 0 1",
                     q_en, count, q_pc, if_ready);
        end
    endtask

    task automatic test_stream();
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_push(ADDR_W'(32'h200 + i));
            step();
            checks++;
            if (count !== 3'd1 || q_en !== 1'b1 || q_pc !== ADDR_W'(32'h200 + i) ||
                q_insn !== mk_insn(ADDR_W'(32'h200 + i))) begin
                errors++;
                $display("FAIL stream[%0d]: got cnt=%0d qen=%b pc=%h want cnt=1 pc=%h",
                         i, count, q_en, q_pc, 32'h200 + i);
            end
        end
        if_en = 1'b0;
        step();
        checks++;
        if (count !== 3'd0 || q_en !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got cnt=%0d qen=%b want 0 0", count, q_en);
        end
    endtask

    task automatic test_load_use();
        dec_ready = 1'b0;
        if_en = 1'b1; if_pc = ADDR_W'(32'h300);
        if_insn = {6'h0, 5'd7, 5'd3, 16'h0300};
        step();
        if_en = 1'b0;
        ex_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd3; dec_ready = 1'b1;
        #1;
        checks++;
        if (ld_hazard !== 1'b1 || q_rs1 !== 5'd3 || q_rs0 !== 5'd7 || ld_stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL hazard_rise: got hz=%b rs0=%0d rs1=%0d st=%0d want 1 7 3 0",
                     ld_hazard, q_rs0, q_rs1, ld_stall_cnt);
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (q_en !== 1'b1 || q_pc !== ADDR_W'(32'h300) || ld_stall_cnt !== 2'(i)) begin
                errors++;
                $display("FAIL hazard_hold[%0d]: got qen=%b pc=%h st=%0d want 1 300 %0d",
                         i, q_en, q_pc, ld_stall_cnt, i);
            end
        end
        ex_is_load = 1'b0;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_drop: got %b want 0", ld_hazard);
        end
        step();
        ex_en = 1'b0;
        checks++;
        if (q_en !== 1'b0 || count !== 3'd0 || ld_stall_cnt !== 2'd2) begin
            errors++;
            $display("FAIL hazard_release_pop: got qen=%b cnt=%0d st=%0d want 0 0 2",
                     q_en, count, ld_stall_cnt);
        end
    endtask

    task automatic test_flush();
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(ADDR_W'(32'h400 + i));
            step();
        end
        drive_push(ADDR_W'(32'h403));
        flush = 1'b1;
        step();
        flush = 1'b0; if_en = 1'b0;
        checks++;
        if (count !== 3'd0 || q_en !== 1'b0 || q_insn !== '0 || if_ready !== 1'b1 ||
            ld_stall_cnt !== 2'd2) begin
            errors++;
            $display("FAIL flush: got cnt=%0d qen=%b insn=%h rdy=%b st=%0d want 0 0 0 1 2",
                     count, q_en, q_insn, if_ready, ld_stall_cnt);
        end
        drive_push(ADDR_W'(32'h500));
        step();
        if_en = 1'b0;
        checks++;
        if (count !== 3'd1 || q_pc !== ADDR_W'(32'h500)) begin
            errors++;
            $display("FAIL post_flush_push: got cnt=%0d pc=%h want 1 500", count, q_pc);
        end
        dec_ready = 1'b1;
        step();
    endtask

    task automatic test_full_pop();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(ADDR_W'(32'h600 + i));
            step();
        end
        drive_push(ADDR_W'(32'h604));
        dec_ready = 1'b1;
        step();
        if_en = 1'b0;
        checks++;
        if (count !== 3'd3 || q_pc !== ADDR_W'(32'h601)) begin
            errors++;
            $display("FAIL full_pop_refuse: got cnt=%0d pc=%h want 3 601", count, q_pc);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (q_pc !== ADDR_W'(32'h600 + i)) begin
                errors++;
                $display("FAIL full_pop_order[%0d]: got %h want %h", i, q_pc, 32'h600 + i);
            end
            step();
        end
        checks++;
        if (q_en !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_empty: got qen=%b want 0", q_en);
        end
    endtask

    task automatic test_reset_mid();
        dec_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_push(ADDR_W'(32'h700 + i));
            step();
        end
        drive_push(ADDR_W'(32'h702));
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; if_en = 1'b0;
        check_reset_values("reset_mid");
        // Empty queue reads rs=0; an EX load to r0 must not flag a hazard.
        ex_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd0;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL empty_no_hazard: got %b want 0", ld_hazard);
        end
        ex_en = 1'b0;
        if_en = 1'b1; if_pc = ADDR_W'(32'h800);
        if_insn = {6'h0, 5'd9, 5'd0, 16'h0800};
        step();
        if_en = 1'b0;
        ex_en = 1'b1; ex_dst_addr = 5'd0; dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (ld_stall_cnt !== 2'd3 || q_pc !== ADDR_W'(32'h800) || ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL stall_saturate: got st=%0d pc=%h hz=%b want 3 800 1",
                     ld_stall_cnt, q_pc, ld_hazard);
        end
        ex_en = 1'b0;
        step();
        checks++;
        if (q_en !== 1'b0 || ld_stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL saturate_release: got qen=%b st=%0d want 0 3", q_en, ld_stall_cnt);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_fill_drain();
        test_stream();
        test_load_use();
        test_flush();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
